// File: rtl/parity_frame_checker.sv
// Registered per-word parity check with frame-level parity accumulation and a saturating error count.
// Optional build macro PARITY_STICKY_EN adds a sticky error flag with its own clear input.
module parity_frame_checker #(
    parameter int WIDTH     = 4,
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_in_data,
    input  logic             i_in_par,
    input  logic             i_odd_mode,
    output logic             o_word_par,
    output logic             o_word_err,
    output logic             o_frame_done,
    output logic             o_frame_par,
    output logic [CNT_W-1:0] o_err_count
`ifdef PARITY_STICKY_EN
    ,
    input  logic             i_clr_sticky,
    output logic             o_err_sticky
`endif
);

    localparam int IDX_W = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [IDX_W-1:0] r_idx;
    logic             r_oddLatched;
    logic             r_wordPar;
    logic             r_wordErr;
    logic             r_framePar;
    logic [CNT_W-1:0] r_errCount;

    logic w_beat;
    logic w_dataPar;
    logic w_checkOdd;
    logic w_mismatch;

    assign o_in_ready = reset && (r_state != DONE);
    assign w_beat     = i_in_valid && o_in_ready;
    assign w_dataPar  = ^i_in_data;

    // Word 0 of a frame is checked against the live mode input, later words against the latched one.
    assign w_checkOdd = (r_state == IDLE) ? i_odd_mode : r_oddLatched;
    assign w_mismatch = (w_dataPar ^ i_in_par) != w_checkOdd;

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_beat) w_nextState = ACCUM;
            ACCUM:   if (w_beat && (r_idx == LAST_IDX)) w_nextState = DONE;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_oddLatched <= 1'b0;
            r_wordPar    <= 1'b0;
            r_wordErr    <= 1'b0;
            r_framePar   <= 1'b0;
            r_errCount   <= '0;
        end else begin
            r_state   <= w_nextState;
            r_wordErr <= w_beat && w_mismatch;
            if (r_state == DONE) begin
                r_idx <= '0;
            end
            if (w_beat) begin
                r_wordPar <= w_dataPar;
                if (r_state == IDLE) begin
                    r_oddLatched <= i_odd_mode;
                    r_framePar   <= w_dataPar;
                    r_idx        <= IDX_W'(1);
                end else begin
                    r_framePar <= r_framePar ^ w_dataPar;
                    r_idx      <= r_idx + IDX_W'(1);
                end
                if (w_mismatch && (r_errCount != CNT_MAX)) begin
                    r_errCount <= r_errCount + CNT_W'(1);
                end
            end
        end
    end

    assign o_word_par   = r_wordPar;
    assign o_word_err   = r_wordErr;
    assign o_frame_done = (r_state == DONE);
    assign o_frame_par  = r_framePar;
    assign o_err_count  = r_errCount;

`ifdef PARITY_STICKY_EN
    logic r_errSticky;

    // Setting takes priority so an error arriving with a clear is never lost.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_errSticky <= 1'b0;
        end else if (w_beat && w_mismatch) begin
            r_errSticky <= 1'b1;
        end else if (i_clr_sticky) begin
            r_errSticky <= 1'b0;
        end
    end

    assign o_err_sticky = r_errSticky;
`endif

endmodule

// File: tb/tb_parity_frame_checker.sv
// Table-driven bench for parity_frame_checker with WIDTH=4, FRAME_LEN=4, CNT_W=3.
// Each record is driven on a falling edge; in_ready is checked before the rising edge, registered outputs just after it.
module tb_parity_frame_checker;

    logic       clk;
    logic       reset;
    logic       inValid;
    logic       inReady;
    logic [3:0] inData;
    logic       inPar;
    logic       oddMode;
    logic       wordPar;
    logic       wordErr;
    logic       frameDone;
    logic       framePar;
    logic [2:0] errCount;
`ifdef PARITY_STICKY_EN
    logic       clrSticky;
    logic       errSticky;
`endif

    typedef struct {
        logic       rst;
        logic       v;
        logic [3:0] d;
        logic       p;
        logic       m;
        logic       clr;
        logic       rdy;
        logic       wp;
        logic       we;
        logic       fd;
        logic       fp;
        logic [2:0] ec;
        logic       chkSt;
        logic       st;
    } vec_t;

    vec_t vecs[$];
    int   applied;
    int   miscompares;

    parity_frame_checker #(
        .WIDTH(4),
        .FRAME_LEN(4),
        .CNT_W(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .i_in_valid(inValid),
        .o_in_ready(inReady),
        .i_in_data(inData),
        .i_in_par(inPar),
        .i_odd_mode(oddMode),
        .o_word_par(wordPar),
        .o_word_err(wordErr),
        .o_frame_done(frameDone),
        .o_frame_par(framePar),
        .o_err_count(errCount)
`ifdef PARITY_STICKY_EN
        ,
        .i_clr_sticky(clrSticky),
        .o_err_sticky(errSticky)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rst, input logic v, input logic [3:0] d,
                                input logic p, input logic m, input logic rdy,
                                input logic wp, input logic we, input logic fd,
                                input logic fp, input logic [2:0] ec);
        vec_t r;
        r.rst = rst; r.v = v; r.d = d; r.p = p; r.m = m; r.clr = 1'b0;
        r.rdy = rdy; r.wp = wp; r.we = we; r.fd = fd; r.fp = fp; r.ec = ec;
        r.chkSt = 1'b0; r.st = 1'b0;
        return r;
    endfunction

    // Outputs must be sampled while the record's inputs are still applied.
    task automatic checkOutput(input int idx, input vec_t e, input logic rdySeen);
        logic bad;
        logic stSeen;
        stSeen = 1'b0;
`ifdef PARITY_STICKY_EN
        stSeen = errSticky;
`endif
        applied++;
        bad = (rdySeen !== e.rdy) || (wordPar !== e.wp) || (wordErr !== e.we) ||
              (frameDone !== e.fd) || (framePar !== e.fp) || (errCount !== e.ec) ||
              (e.chkSt && (stSeen !== e.st));
        if (bad) begin
            miscompares++;
            $display("[TB] FAIL vec%0d got rdy=%b wp=%b we=%b fd=%b fp=%b ec=%0d st=%b expected rdy=%b wp=%b we=%b fd=%b fp=%b ec=%0d st=%b",
                     idx, rdySeen, wordPar, wordErr, frameDone, framePar, errCount, stSeen,
                     e.rdy, e.wp, e.we, e.fd, e.fp, e.ec, e.st);
        end
    endtask

    task automatic applyStimulus(input int idx, input vec_t e);
        logic rdySeen;
        @(negedge clk);
        reset   = e.rst;
        inValid = e.v;
        inData  = e.d;
        inPar   = e.p;
        oddMode = e.m;
`ifdef PARITY_STICKY_EN
        clrSticky = e.clr;
`endif
        #1;
        rdySeen = inReady;
        @(posedge clk);
        #1;
        checkOutput(idx, e, rdySeen);
    endtask

    initial begin
        vec_t t;
        applied     = 0;
        miscompares = 0;
        reset   = 1'b0;
        inValid = 1'b0;
        inData  = 4'h0;
        inPar   = 1'b0;
        oddMode = 1'b0;
`ifdef PARITY_STICKY_EN
        clrSticky = 1'b0;
`endif

        // Reset held two cycles, then released idle.
        t = mk(0,0,4'h0,0,0, 0,0,0,0,0,0); t.chkSt = 1'b1; vecs.push_back(t);
        vecs.push_back(mk(0,0,4'h0,0,0, 0,0,0,0,0,0));
        vecs.push_back(mk(1,0,4'h0,0,0, 1,0,0,0,0,0));
        // Even mode, four good words, then the DONE cycle.
        vecs.push_back(mk(1,1,4'b0011,0,0, 1,0,0,0,0,0));
        vecs.push_back(mk(1,1,4'b0111,1,0, 1,1,0,0,1,0));
        vecs.push_back(mk(1,1,4'b1000,1,0, 1,1,0,0,0,0));
        vecs.push_back(mk(1,1,4'b1111,0,0, 1,0,0,1,0,0));
        vecs.push_back(mk(1,0,4'h0,0,0, 0,0,0,0,0,0));
        // Odd mode latched at word 0; odd_mode flips to 0 mid-frame, gap in the middle.
        vecs.push_back(mk(1,1,4'b0000,0,1, 1,0,1,0,0,1));
        vecs.push_back(mk(1,1,4'b0001,0,0, 1,1,0,0,1,1));
        vecs.push_back(mk(1,0,4'b0000,0,0, 1,1,0,0,1,1));
        vecs.push_back(mk(1,1,4'b0011,0,0, 1,0,1,0,1,2));
        vecs.push_back(mk(1,1,4'b0001,0,0, 1,1,0,1,0,2));
        vecs.push_back(mk(1,0,4'h0,0,0, 0,1,0,0,0,2));
        // in_valid held high for ten words; the word offered in the DONE cycle is re-offered.
        vecs.push_back(mk(1,1,4'd0,0,0, 1,0,0,0,0,2));
        vecs.push_back(mk(1,1,4'd1,1,0, 1,1,0,0,1,2));
        vecs.push_back(mk(1,1,4'd2,1,0, 1,1,0,0,0,2));
        vecs.push_back(mk(1,1,4'd3,0,0, 1,0,0,1,0,2));
        vecs.push_back(mk(1,1,4'd4,1,0, 0,0,0,0,0,2));
        vecs.push_back(mk(1,1,4'd4,1,0, 1,1,0,0,1,2));
        vecs.push_back(mk(1,1,4'd5,0,0, 1,0,0,0,1,2));
        vecs.push_back(mk(1,1,4'd6,0,0, 1,0,0,0,1,2));
        vecs.push_back(mk(1,1,4'd7,1,0, 1,1,0,1,0,2));
        vecs.push_back(mk(1,1,4'd8,1,0, 0,1,0,0,0,2));
        vecs.push_back(mk(1,1,4'd8,1,0, 1,1,0,0,1,2));
        vecs.push_back(mk(1,1,4'd9,0,0, 1,0,0,0,1,2));
        vecs.push_back(mk(1,0,4'd0,0,0, 1,0,0,0,1,2));
        vecs.push_back(mk(1,1,4'd10,0,0, 1,0,0,0,1,2));
        vecs.push_back(mk(1,1,4'd11,1,0, 1,1,0,1,0,2));
        vecs.push_back(mk(1,0,4'd0,0,0, 0,1,0,0,0,2));
        // Reset, then eight bad words back to back: count saturates at 7.
        vecs.push_back(mk(0,0,4'd0,0,0, 0,0,0,0,0,0));
        vecs.push_back(mk(1,1,4'b0001,0,0, 1,1,1,0,1,1));
        vecs.push_back(mk(1,1,4'b0001,0,0, 1,1,1,0,0,2));
        vecs.push_back(mk(1,1,4'b0001,0,0, 1,1,1,0,1,3));
        vecs.push_back(mk(1,1,4'b0001,0,0, 1,1,1,1,0,4));
        vecs.push_back(mk(1,1,4'b0001,0,0, 0,1,0,0,0,4));
        vecs.push_back(mk(1,1,4'b0001,0,0, 1,1,1,0,1,5));
        vecs.push_back(mk(1,1,4'b0001,0,0, 1,1,1,0,0,6));
        vecs.push_back(mk(1,1,4'b0001,0,0, 1,1,1,0,1,7));
        vecs.push_back(mk(1,1,4'b0001,0,0, 1,1,1,1,0,7));
        vecs.push_back(mk(1,0,4'b0000,0,0, 0,1,0,0,0,7));
        // Reset two beats into a frame; the first beat afterwards starts a new frame.
        vecs.push_back(mk(1,1,4'b1000,1,0, 1,1,0,0,1,7));
        vecs.push_back(mk(1,1,4'b0001,1,0, 1,1,0,0,0,7));
        vecs.push_back(mk(0,1,4'b0011,0,0, 0,0,0,0,0,0));
        vecs.push_back(mk(1,1,4'b0011,0,0, 1,0,0,0,0,0));
        vecs.push_back(mk(1,1,4'b0010,1,0, 1,1,0,0,1,0));
        vecs.push_back(mk(1,1,4'b0100,1,0, 1,1,0,0,0,0));
        vecs.push_back(mk(1,1,4'b0111,1,0, 1,1,0,1,1,0));
        vecs.push_back(mk(1,0,4'b0000,0,0, 0,1,0,0,1,0));
`ifdef PARITY_STICKY_EN
        // Sticky flag: set by an error, survives a gap, set beats clear, then clears.
        t = mk(1,1,4'b0000,1,0, 1,0,1,0,0,1); t.chkSt = 1'b1; t.st = 1'b1; vecs.push_back(t);
        t = mk(1,0,4'b0000,0,0, 1,0,0,0,0,1); t.chkSt = 1'b1; t.st = 1'b1; vecs.push_back(t);
        t = mk(1,1,4'b0000,1,0, 1,0,1,0,0,2); t.clr = 1'b1; t.chkSt = 1'b1; t.st = 1'b1; vecs.push_back(t);
        t = mk(1,0,4'b0000,0,0, 1,0,0,0,0,2); t.clr = 1'b1; t.chkSt = 1'b1; t.st = 1'b0; vecs.push_back(t);
        t = mk(1,0,4'b0000,0,0, 1,0,0,0,0,2); t.chkSt = 1'b1; t.st = 1'b0; vecs.push_back(t);
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(i, vecs[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
